// File: rtl/hyperbus_responder.sv
// HyperBus responder: HyperRAM-style device with a 64 x 16-bit array, fixed 1x latency.
// hb_clk_i is oversampled by wb_clk_i; every level change is one bus edge.
module hyperbus_responder #(
  parameter int          LATENCY = 6,
  parameter logic [15:0] ID0     = 16'h0C81
) (
  input  logic       wb_clk_i,
  input  logic       wb_rstn_i,
  input  logic       hb_rstn_i,
  input  logic       hb_csn_i,
  input  logic       hb_clk_i,
  input  logic       hb_rwds_i,
  output logic       hb_rwds_o,
  output logic       hb_rwds_oen,
  input  logic [7:0] hb_dq_i,
  output logic [7:0] hb_dq_o,
  output logic       hb_dq_oen
);
  localparam logic [3:0] LAT_LAST = 4'(2 * LATENCY - 3);

  typedef enum logic [2:0] {IDLE, CA, LAT, WDATA, RDATA} state_t;
  state_t r_state, w_next;

  logic        r_hb_clk;
  logic [39:0] r_ca;
  logic [3:0]  r_cnt;
  logic        r_half;
  logic [5:0]  r_addr;
  logic        r_rd, r_reg, r_lin;
  logic [7:0]  r_wbyte;
  logic        r_wmask;
  logic [7:0]  r_dq_o;
  logic        r_rwds;
  logic [15:0] r_mem [64];

  logic        w_edge;
  logic [47:0] w_ca;
  logic        w_ca_unused;
  logic [5:0]  w_addr_inc;
  logic [15:0] w_rdata;
  logic        w_wr_word;

  assign w_edge      = (hb_clk_i != r_hb_clk) && !hb_csn_i;
  assign w_ca        = {r_ca, hb_dq_i};
  assign w_ca_unused = ^{w_ca[44:19], w_ca[15:3]};
  assign w_addr_inc  = r_lin ? r_addr + 6'd1 : {r_addr[5:3], r_addr[2:0] + 3'd1};
  assign w_rdata     = r_reg ? ((r_addr == 6'd0) ? ID0 : 16'h0000) : r_mem[r_addr];
  assign w_wr_word   = w_edge && hb_rstn_i && (r_state == WDATA) && r_half && !r_reg;

  assign hb_dq_oen   = (r_state != RDATA);
  assign hb_rwds_oen = !((r_state == CA) || (r_state == RDATA));
  assign hb_rwds_o   = (r_state == RDATA) && r_rwds;
  assign hb_dq_o     = r_dq_o;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i)
    if (!wb_rstn_i) r_state <= IDLE;
    else            r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (hb_csn_i || !hb_rstn_i) w_next = IDLE;
    else begin
      case (r_state)
        IDLE: w_next = CA;
        CA:   if (w_edge && r_cnt == 4'd5) w_next = (!w_ca[47] && w_ca[46]) ? WDATA : LAT;
        LAT:  if (w_edge && r_cnt == LAT_LAST) w_next = r_rd ? RDATA : WDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_hb_clk <= 1'b0;
      r_ca     <= '0;
      r_cnt    <= '0;
      r_half   <= 1'b0;
      r_addr   <= '0;
      r_rd     <= 1'b0;
      r_reg    <= 1'b0;
      r_lin    <= 1'b0;
      r_wbyte  <= '0;
      r_wmask  <= 1'b0;
      r_dq_o   <= '0;
      r_rwds   <= 1'b0;
    end else begin
      r_hb_clk <= hb_clk_i;
      if (r_state == IDLE) begin
        r_cnt  <= '0;
        r_half <= 1'b0;
      end
      if (w_edge && hb_rstn_i) begin
        case (r_state)
          CA: begin
            r_ca  <= w_ca[39:0];
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd5) begin
              r_cnt  <= '0;
              r_rd   <= w_ca[47];
              r_reg  <= w_ca[46];
              r_lin  <= w_ca[45];
              r_addr <= {w_ca[18:16], w_ca[2:0]};
            end
          end
          LAT: begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == LAT_LAST) begin
              r_dq_o <= w_rdata[15:8];
              r_rwds <= 1'b1;
            end
          end
          WDATA: begin
            r_half <= !r_half;
            if (!r_half) begin
              r_wbyte <= hb_dq_i;
              r_wmask <= hb_rwds_i;
            end else begin
              r_addr <= w_addr_inc;
            end
          end
          RDATA: begin
            // address advances with the low byte, so the next high byte reads the new word
            r_half <= !r_half;
            r_rwds <= !r_rwds;
            if (!r_half) begin
              r_dq_o <= w_rdata[7:0];
              r_addr <= w_addr_inc;
            end else begin
              r_dq_o <= w_rdata[15:8];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_wr_word) begin
      if (!r_wmask)   r_mem[r_addr][15:8] <= r_wbyte;
      if (!hb_rwds_i) r_mem[r_addr][7:0]  <= hb_dq_i;
    end
  end
endmodule

// File: tb/tb_hyperbus_responder.sv
// Randomized bench for hyperbus_responder against a word-level memory model.
module tb_hyperbus_responder;
  localparam int LAT = 6;

  logic       clk = 0, rstn = 0, hb_rstn = 1, csn = 1, hbclk = 0, rwds_i = 0;
  logic [7:0] dq_i = 0;
  logic       rwds_o, rwds_oen, dq_oen;
  logic [7:0] dq_o;

  int total = 0, bad = 0;
  logic [15:0] model [64];
  logic [15:0] wq[$];
  logic [1:0]  mq[$];
  logic [10:0] rq[$], eq[$];

  hyperbus_responder #(.LATENCY(LAT), .ID0(16'h0C81)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rstn), .hb_rstn_i(hb_rstn), .hb_csn_i(csn),
    .hb_clk_i(hbclk), .hb_rwds_i(rwds_i), .hb_rwds_o(rwds_o), .hb_rwds_oen(rwds_oen),
    .hb_dq_i(dq_i), .hb_dq_o(dq_o), .hb_dq_oen(dq_oen));

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [5:0] nxt(input logic [5:0] a, input bit lin);
    int v;
    v = lin ? (a + 1) % 64 : (a / 8) * 8 + (a + 1) % 8;
    return 6'(v);
  endfunction

  function automatic logic [15:0] mword(input bit rs, input logic [5:0] a);
    if (rs) return (a == 6'd0) ? 16'h0C81 : 16'h0000;
    return model[a];
  endfunction

  // expected read stream: high byte with RWDS=1, low byte with RWDS=0, both outputs enabled
  task automatic exp_build(input bit rs, input bit lin, input logic [5:0] a0, input int n);
    logic [5:0] a;
    logic [15:0] w;
    a = a0;
    eq.delete();
    for (int i = 0; i < n; i++) begin
      w = mword(rs, a);
      eq.push_back({3'b001, w[15:8]});
      eq.push_back({3'b000, w[7:0]});
      a = nxt(a, lin);
    end
  endtask

  task automatic hb_edge(input logic [7:0] d, input logic m);
    dq_i = d; rwds_i = m; hbclk = ~hbclk;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_ca(input bit rd, input bit rs, input bit lin, input logic [5:0] a);
    logic [47:0] ca;
    ca = 48'({$urandom, $urandom});
    ca[47] = rd; ca[46] = rs; ca[45] = lin;
    ca[18:16] = a[5:3]; ca[2:0] = a[2:0];
    csn = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) hb_edge(ca[47-8*i -: 8], 1'b0);
  endtask

  task automatic lat_edges();
    repeat (2*LAT-2) hb_edge(8'($urandom), 1'($urandom));
  endtask

  task automatic sample();
    rq.push_back({dq_oen, rwds_oen, rwds_o, dq_o});
  endtask

  task automatic hb_write(input bit rs, input bit lin, input logic [5:0] a0);
    logic [5:0] a;
    send_ca(1'b0, rs, lin, a0);
    if (!rs) lat_edges();
    foreach (wq[i]) begin
      hb_edge(wq[i][15:8], mq[i][1]);
      hb_edge(wq[i][7:0], mq[i][0]);
    end
    csn = 1;
    @(negedge clk);
    a = a0;
    if (!rs)
      foreach (wq[i]) begin
        if (!mq[i][1]) model[a][15:8] = wq[i][15:8];
        if (!mq[i][0]) model[a][7:0]  = wq[i][7:0];
        a = nxt(a, lin);
      end
  endtask

  task automatic hb_read(input bit rs, input bit lin, input logic [5:0] a0, input int n);
    rq.delete();
    send_ca(1'b1, rs, lin, a0);
    lat_edges();
    sample();
    for (int i = 1; i < 2*n; i++) begin
      hb_edge(8'($urandom), 1'b0);
      sample();
    end
    csn = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({dq_oen, rwds_oen, rwds_o, dq_o} !== 11'b110_0000_0000) begin
      bad++; $display("FAIL reset_in got %h want %h", {dq_oen, rwds_oen, rwds_o, dq_o}, 11'h600);
    end
    rstn = 1;
    repeat (3) @(negedge clk);
    total++;
    if ({dq_oen, rwds_oen, rwds_o, dq_o} !== 11'b110_0000_0000) begin
      bad++; $display("FAIL reset_out got %h want %h", {dq_oen, rwds_oen, rwds_o, dq_o}, 11'h600);
    end
  endtask

  task automatic test_fill();
    wq.delete(); mq.delete();
    for (int i = 0; i < 64; i++) begin wq.push_back(16'($urandom)); mq.push_back(2'b00); end
    hb_write(1'b0, 1'b1, 6'd0);
    hb_read(1'b0, 1'b1, 6'd0, 64);
    exp_build(1'b0, 1'b1, 6'd0, 64);
    for (int i = 0; i < eq.size(); i++) begin
      total++;
      if (rq[i] !== eq[i]) begin bad++; $display("FAIL fill[%0d] got %h want %h", i, rq[i], eq[i]); end
    end
  endtask

  task automatic test_ca_rwds();
    csn = 0;
    @(negedge clk);
    hb_edge(8'h80, 1'b0);
    total++;
    if ({rwds_oen, rwds_o} !== 2'b00) begin bad++; $display("FAIL ca_rwds got %b want 00", {rwds_oen, rwds_o}); end
    csn = 1;
    @(negedge clk);
    total++;
    if ({dq_oen, rwds_oen} !== 2'b11) begin bad++; $display("FAIL ca_abort_oen got %b want 11", {dq_oen, rwds_oen}); end
  endtask

  task automatic test_linear();
    logic [10:0] exp [4];
    exp = '{11'h1A5, 11'h05A, 11'h112, 11'h034};
    wq = '{16'hA55A, 16'h1234}; mq = '{2'b00, 2'b00};
    hb_write(1'b0, 1'b1, 6'd5);
    hb_read(1'b0, 1'b1, 6'd5, 2);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rq[i] !== exp[i]) begin bad++; $display("FAIL linear[%0d] got %h want %h", i, rq[i], exp[i]); end
    end
  endtask

  task automatic test_mask();
    logic [15:0] prior;
    prior = model[9];
    wq = '{16'hFFFF}; mq = '{2'b10};
    hb_write(1'b0, 1'b1, 6'd9);
    hb_read(1'b0, 1'b1, 6'd9, 1);
    total++;
    if ({rq[0][7:0], rq[1][7:0]} !== {prior[15:8], 8'hFF}) begin
      bad++; $display("FAIL mask got %h want %h", {rq[0][7:0], rq[1][7:0]}, {prior[15:8], 8'hFF});
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp [4];
    exp = '{model[6], model[7], model[0], model[1]};
    hb_read(1'b0, 1'b0, 6'd6, 4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({rq[2*i][7:0], rq[2*i+1][7:0]} !== exp[i]) begin
        bad++; $display("FAIL wrap[%0d] got %h want %h", i, {rq[2*i][7:0], rq[2*i+1][7:0]}, exp[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [15:0] prior;
    prior = model[3];
    send_ca(1'b0, 1'b0, 1'b1, 6'd3);
    lat_edges();
    hb_edge(~prior[15:8], 1'b0);
    csn = 1;
    @(negedge clk);
    total++;
    if ({dq_oen, rwds_oen} !== 2'b11) begin bad++; $display("FAIL abort_wr_oen got %b want 11", {dq_oen, rwds_oen}); end
    hb_read(1'b0, 1'b1, 6'd3, 1);
    total++;
    if ({rq[0][7:0], rq[1][7:0]} !== prior) begin
      bad++; $display("FAIL abort_mem got %h want %h", {rq[0][7:0], rq[1][7:0]}, prior);
    end
    send_ca(1'b1, 1'b0, 1'b1, 6'd10);
    lat_edges();
    csn = 1;
    @(negedge clk);
    total++;
    if ({dq_oen, rwds_oen} !== 2'b11) begin bad++; $display("FAIL abort_rd_oen got %b want 11", {dq_oen, rwds_oen}); end
  endtask

  task automatic test_latency();
    int edges;
    logic [5:0] a;
    a = 6'($urandom);
    send_ca(1'b1, 1'b0, 1'b1, a);
    edges = 0;
    while (dq_oen === 1'b1 && edges < 40) begin
      hb_edge(8'($urandom), 1'b0);
      edges++;
    end
    total++;
    if (edges != 2*LAT-2) begin bad++; $display("FAIL latency got %0d want %0d edges", edges, 2*LAT-2); end
    total++;
    if ({rwds_o, dq_o} !== {1'b1, model[a][15:8]}) begin
      bad++; $display("FAIL latency_byte got %h want %h", {rwds_o, dq_o}, {1'b1, model[a][15:8]});
    end
    csn = 1;
    @(negedge clk);
  endtask

  task automatic test_hb_reset();
    logic [5:0] a;
    logic [15:0] w0, w1;
    a = 6'($urandom); w0 = 16'($urandom); w1 = 16'($urandom);
    send_ca(1'b0, 1'b0, 1'b1, a);
    lat_edges();
    hb_edge(w0[15:8], 1'b0); hb_edge(w0[7:0], 1'b0);
    hb_edge(w1[15:8], 1'b0);
    hb_rstn = 0;
    repeat (8) hb_edge(8'($urandom), 1'b0);
    total++;
    if ({dq_oen, rwds_oen} !== 2'b11) begin bad++; $display("FAIL hbrst_hold got %b want 11", {dq_oen, rwds_oen}); end
    csn = 1; hb_rstn = 1;
    @(negedge clk);
    model[a] = w0;
    hb_read(1'b0, 1'b1, a, 2);
    exp_build(1'b0, 1'b1, a, 2);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rq[i] !== eq[i]) begin bad++; $display("FAIL hbrst_mem[%0d] got %h want %h", i, rq[i], eq[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] a;
    a = 6'($urandom);
    wq = '{16'($urandom)}; mq = '{2'b00};
    hb_write(1'b1, 1'b1, a);
    hb_write(1'b0, 1'b1, a);
    wq = '{~model[a]}; mq = '{2'b00};
    hb_write(1'b1, 1'b1, a);
    hb_read(1'b0, 1'b1, a, 1);
    total++;
    if ({rq[0][7:0], rq[1][7:0]} !== model[a]) begin
      bad++; $display("FAIL b2b got %h want %h", {rq[0][7:0], rq[1][7:0]}, model[a]);
    end
  endtask

  task automatic test_random();
    bit rd, rs, lin;
    int n;
    logic [5:0] a;
    for (int t = 0; t < 30; t++) begin
      rd = 1'($urandom); rs = ($urandom_range(0, 3) == 0); lin = 1'($urandom);
      a = 6'($urandom); n = $urandom_range(1, 4);
      if (!rd) begin
        wq.delete(); mq.delete();
        for (int i = 0; i < n; i++) begin wq.push_back(16'($urandom)); mq.push_back(2'($urandom)); end
        hb_write(rs, lin, a);
      end else begin
        hb_read(rs, lin, a, n);
        exp_build(rs, lin, a, n);
        for (int i = 0; i < eq.size(); i++) begin
          total++;
          if (rq[i] !== eq[i]) begin
            bad++; $display("FAIL rand%0d[%0d] rs=%0d lin=%0d a=%0d got %h want %h", t, i, rs, lin, a, rq[i], eq[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reg_read();
    logic [5:0] a;
    hb_read(1'b1, 1'b1, 6'd0, 1);
    total++;
    if ({rq[0], rq[1]} !== {11'h10C, 11'h081}) begin
      bad++; $display("FAIL reg_id got %h %h want 10c 081", rq[0], rq[1]);
    end
    a = 6'($urandom_range(1, 63));
    hb_read(1'b1, 1'b1, a, 1);
    total++;
    if ({rq[0], rq[1]} !== {11'h100, 11'h000}) begin
      bad++; $display("FAIL reg_zero got %h %h want 100 000", rq[0], rq[1]);
    end
    send_ca(1'b1, 1'b1, 1'b1, 6'd0);
    lat_edges();
    total++;
    if ({dq_oen, dq_o} !== 9'h00C) begin bad++; $display("FAIL reg_mid got %h want 00c", {dq_oen, dq_o}); end
    #2 rstn = 0;
    #1;
    total++;
    if ({dq_oen, rwds_oen, rwds_o, dq_o} !== 11'h600) begin
      bad++; $display("FAIL wb_reset_mid got %h want 600", {dq_oen, rwds_oen, rwds_o, dq_o});
    end
    csn = 1;
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    hb_read(1'b1, 1'b1, 6'd0, 1);
    total++;
    if ({rq[0], rq[1]} !== {11'h10C, 11'h081}) begin
      bad++; $display("FAIL reg_after_rst got %h %h want 10c 081", rq[0], rq[1]);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ca_rwds();
    test_linear();
    test_mask();
    test_wrap();
    test_abort();
    test_latency();
    test_hb_reset();
    test_back_to_back();
    test_random();
    test_reg_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
